// File: rtl/bellman_ford_engine.sv
// Bellman-Ford shortest-path engine: sweeps every (i,j) adjacency slot per pass over a
// dual-port {pred,dist} vertex RAM, exits early on a quiet pass and ends with a negative-cycle check.
`timescale 1ns/1ps
module bellman_ford_engine #(
   parameter int NODES    = 8,
   parameter int WEIGHT_W = 32,
   parameter int PRED_W   = $clog2(NODES)
) (
   input  logic                       clk,
   input  logic                       bellman_reset_n,
   input  logic                       start,
   input  logic [PRED_W-1:0]          src,
   output logic [PRED_W-1:0]          adjmat_row_addr,
   output logic [PRED_W-1:0]          adjmat_col_addr,
   input  logic [WEIGHT_W-1:0]        adjmat_q,
   output logic [PRED_W-1:0]          vertmat_addr_a,
   output logic [PRED_W+WEIGHT_W-1:0] vertmat_data_a,
   output logic                       vertmat_we_a,
   input  logic [PRED_W+WEIGHT_W-1:0] vertmat_q_a,
   output logic [PRED_W-1:0]          vertmat_addr_b,
   output logic [PRED_W+WEIGHT_W-1:0] vertmat_data_b,
   output logic                       vertmat_we_b,
   input  logic [PRED_W+WEIGHT_W-1:0] vertmat_q_b,
   output logic                       busy,
   output logic                       done,
   output logic                       neg_cycle,
   output logic [PRED_W-1:0]          cycle_vertex,
   output logic [PRED_W:0]            passes_used
);
   localparam logic signed [WEIGHT_W-1:0] INF     = {1'b0, {(WEIGHT_W-1){1'b1}}};
   localparam logic signed [WEIGHT_W-1:0] NEG_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};
   localparam logic [PRED_W-1:0]          LAST    = PRED_W'(NODES - 1);
   localparam logic [PRED_W-1:0]          ONE     = PRED_W'(1);
   localparam logic [PRED_W:0]            LAST_PASS = (PRED_W+1)'(NODES - 1);
   localparam logic [PRED_W:0]            PASS_ONE  = (PRED_W+1)'(1);

   typedef enum logic [3:0] {
      S_IDLE, S_INIT, S_READ, S_WAIT, S_RELAX, S_PASS_END,
      S_CHK_READ, S_CHK_WAIT, S_CHECK, S_DONE
   } state_t;

   state_t              state, state_nxt;
   logic [PRED_W-1:0]   i_q, i_nxt, j_q, j_nxt, k_q, k_nxt, src_q, src_nxt;
   logic [PRED_W-1:0]   cv_nxt;
   logic [PRED_W:0]     passes_nxt;
   logic                upd_q, upd_nxt, neg_nxt;

   logic signed [WEIGHT_W-1:0] e, svw, dvw, sum_sat, init_dist;
   logic signed [WEIGHT_W:0]   sum_wide;
   logic                       relax_ok, last_j, last_slot;
   logic                       unused_pred;

   assign e         = adjmat_q;
   assign svw       = vertmat_q_a[WEIGHT_W-1:0];
   assign dvw       = vertmat_q_b[WEIGHT_W-1:0];
   assign unused_pred = ^{vertmat_q_a[PRED_W+WEIGHT_W-1:WEIGHT_W], vertmat_q_b[PRED_W+WEIGHT_W-1:WEIGHT_W]};

   // One extra bit catches overflow; the two top bits disagree exactly when the sum left range.
   assign sum_wide  = {svw[WEIGHT_W-1], svw} + {e[WEIGHT_W-1], e};
   assign sum_sat   = (sum_wide[WEIGHT_W] != sum_wide[WEIGHT_W-1]) ?
                      (sum_wide[WEIGHT_W] ? NEG_MIN : INF) : sum_wide[WEIGHT_W-1:0];
   assign relax_ok  = (e != '0) && (svw != INF) && (sum_sat < dvw);
   assign last_j    = (j_q == LAST);
   assign last_slot = last_j && (i_q == LAST);
   assign init_dist = (k_q == src_q) ? '0 : INF;

   assign adjmat_row_addr = i_q;
   assign adjmat_col_addr = j_q;
   assign vertmat_addr_a  = (state == S_INIT) ? k_q : i_q;
   assign vertmat_addr_b  = j_q;
   assign vertmat_we_a    = (state == S_INIT);
   assign vertmat_data_a  = vertmat_we_a ? {k_q, init_dist} : '0;
   assign vertmat_we_b    = (state == S_RELAX) && relax_ok;
   assign vertmat_data_b  = vertmat_we_b ? {i_q, sum_sat} : '0;
   assign busy            = (state != S_IDLE) && (state != S_DONE);
   assign done            = (state == S_DONE);

   always_comb begin
      state_nxt  = state;
      i_nxt      = i_q;
      j_nxt      = j_q;
      k_nxt      = k_q;
      src_nxt    = src_q;
      upd_nxt    = upd_q;
      passes_nxt = passes_used;
      neg_nxt    = neg_cycle;
      cv_nxt     = cycle_vertex;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               src_nxt    = src;
               passes_nxt = '0;
               neg_nxt    = 1'b0;
               cv_nxt     = '0;
               k_nxt      = '0;
               state_nxt  = S_INIT;
            end
         end
         S_INIT: begin
            k_nxt = k_q + ONE;
            if (k_q == LAST) begin
               k_nxt     = '0;
               i_nxt     = '0;
               j_nxt     = '0;
               upd_nxt   = 1'b0;
               state_nxt = S_READ;
            end
         end
         S_READ:     state_nxt = S_WAIT;
         S_WAIT:     state_nxt = S_RELAX;
         S_RELAX: begin
            if (relax_ok) upd_nxt = 1'b1;
            if (last_slot) begin
               state_nxt = S_PASS_END;
            end else begin
               j_nxt     = last_j ? '0 : j_q + ONE;
               i_nxt     = last_j ? i_q + ONE : i_q;
               state_nxt = S_READ;
            end
         end
         S_PASS_END: begin
            passes_nxt = passes_used + PASS_ONE;
            i_nxt      = '0;
            j_nxt      = '0;
            if (!upd_q || (passes_used + PASS_ONE) == LAST_PASS) begin
               state_nxt = S_CHK_READ;
            end else begin
               upd_nxt   = 1'b0;
               state_nxt = S_READ;
            end
         end
         S_CHK_READ: state_nxt = S_CHK_WAIT;
         S_CHK_WAIT: state_nxt = S_CHECK;
         S_CHECK: begin
            if (relax_ok) begin
               neg_nxt   = 1'b1;
               cv_nxt    = j_q;
               state_nxt = S_DONE;
            end else if (last_slot) begin
               state_nxt = S_DONE;
            end else begin
               j_nxt     = last_j ? '0 : j_q + ONE;
               i_nxt     = last_j ? i_q + ONE : i_q;
               state_nxt = S_CHK_READ;
            end
         end
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!bellman_reset_n) begin
         state        <= S_IDLE;
         i_q          <= '0;
         j_q          <= '0;
         k_q          <= '0;
         src_q        <= '0;
         upd_q        <= 1'b0;
         passes_used  <= '0;
         neg_cycle    <= 1'b0;
         cycle_vertex <= '0;
      end else begin
         state        <= state_nxt;
         i_q          <= i_nxt;
         j_q          <= j_nxt;
         k_q          <= k_nxt;
         src_q        <= src_nxt;
         upd_q        <= upd_nxt;
         passes_used  <= passes_nxt;
         neg_cycle    <= neg_nxt;
         cycle_vertex <= cv_nxt;
      end
   end
endmodule

// File: tb/tb_bellman_ford_engine.sv
// Bench for bellman_ford_engine: RAM models around the DUT, a graph-level shortest-path
// reference, and a done-triggered monitor popping expected results from queues.
`timescale 1ns/1ps
module tb_bellman_ford_engine;
   localparam int N  = 8;
   localparam int W  = 16;
   localparam int PW = $clog2(N);
   localparam int VW = PW + W;
   localparam longint INF  = 32767;
   localparam longint MINV = -32768;
   localparam int TIMEOUT = 5000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [PW-1:0] src = '0;
   logic [PW-1:0] row_addr, col_addr, addr_a, addr_b, cycle_vertex;
   logic [W-1:0]  adjmat_q = '0;
   logic [VW-1:0] data_a, data_b;
   logic [VW-1:0] q_a = '0, q_b = '0;
   logic          we_a, we_b, busy, done, neg_cycle;
   logic [PW:0]   passes_used;

   int checks = 0;
   int errors = 0;

   logic [7:0]    exp_res_q[$];
   logic [31:0]   exp_lat_q[$];
   logic [VW-1:0] exp_mem_q[$];

   logic [W-1:0]  adj [N][N];
   logic [VW-1:0] vm [N];
   logic [W-1:0]  adj_r1 = '0;
   logic [VW-1:0] a_r1 = '0, b_r1 = '0;
   logic [31:0]   busy_cnt = '0;
   logic          done_q = 1'b0;

   bellman_ford_engine #(.NODES(N), .WEIGHT_W(W)) dut (
      .clk(clk), .bellman_reset_n(rst_n), .start(start), .src(src),
      .adjmat_row_addr(row_addr), .adjmat_col_addr(col_addr), .adjmat_q(adjmat_q),
      .vertmat_addr_a(addr_a), .vertmat_data_a(data_a), .vertmat_we_a(we_a), .vertmat_q_a(q_a),
      .vertmat_addr_b(addr_b), .vertmat_data_b(data_b), .vertmat_we_b(we_b), .vertmat_q_b(q_b),
      .busy(busy), .done(done), .neg_cycle(neg_cycle), .cycle_vertex(cycle_vertex),
      .passes_used(passes_used)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   // Two-cycle read latency memories
   always @(posedge clk) begin
      adj_r1   <= adj[row_addr][col_addr];
      adjmat_q <= adj_r1;
      if (we_a) vm[addr_a] <= data_a;
      if (we_b) vm[addr_b] <= data_b;
      a_r1 <= vm[addr_a];
      q_a  <= a_r1;
      b_r1 <= vm[addr_b];
      q_b  <= b_r1;
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reference: textbook Bellman-Ford over the adjacency array, in-place updates, slot order i then j
   task automatic model_run(input int s);
      longint d [N];
      int     p [N];
      longint e, sum;
      bit     upd, found;
      int     passes, slots, cv;
      for (int v = 0; v < N; v++) begin
         d[v] = (v == s) ? 0 : INF;
         p[v] = v;
      end
      passes = 0;
      do begin
         upd = 0;
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               e = longint'($signed(adj[i][j]));
               if (e != 0 && d[i] != INF) begin
                  sum = d[i] + e;
                  if (sum > INF) sum = INF;
                  if (sum < MINV) sum = MINV;
                  if (sum < d[j]) begin
                     d[j] = sum;
                     p[j] = i;
                     upd  = 1;
                  end
               end
            end
         passes++;
      end while (upd && passes < N - 1);
      found = 0; slots = 0; cv = 0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (!found) begin
               slots++;
               e = longint'($signed(adj[i][j]));
               if (e != 0 && d[i] != INF) begin
                  sum = d[i] + e;
                  if (sum > INF) sum = INF;
                  if (sum < MINV) sum = MINV;
                  if (sum < d[j]) begin
                     found = 1;
                     cv    = j;
                  end
               end
            end
      exp_res_q.push_back({found, PW'(cv), (PW+1)'(passes)});
      exp_lat_q.push_back(32'(N + passes * (3 * N * N + 1) + 3 * slots));
      for (int v = 0; v < N; v++) exp_mem_q.push_back({PW'(p[v]), W'(d[v])});
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_cnt <= '0;
         done_q   <= 1'b0;
      end else begin
         if (busy) busy_cnt <= busy_cnt + 1;
         if (done && !done_q) begin
            if (exp_res_q.size() == 0 || exp_lat_q.size() == 0 || exp_mem_q.size() < N) begin
               check("unexpected_done", 1, 0);
            end else begin
               check("result_neg_cv_passes", {neg_cycle, cycle_vertex, passes_used}, exp_res_q.pop_front());
               check("busy_cycles", busy_cnt, exp_lat_q.pop_front());
               for (int v = 0; v < N; v++)
                  check($sformatf("vertmat%0d", v), vm[v], exp_mem_q.pop_front());
            end
            busy_cnt <= '0;
         end
         done_q <= done;
      end
   end

   // driver tasks
   task automatic clear_graph();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) adj[i][j] = '0;
   endtask

   task automatic set_edge(input int i, input int j, input int w);
      adj[i][j] = W'(w);
   endtask

   task automatic rand_graph(input int density, input int lo, input int hi, input bit sat);
      int w;
      clear_graph();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (int'($urandom_range(99, 0)) < density) begin
               if (sat) begin
                  w = 30000 + int'($urandom_range(2767, 0));
                  if ($urandom_range(1, 0) == 1) w = -w;
               end else begin
                  w = lo + int'($urandom_range(hi - lo, 0));
               end
               if (w == 0) w = 1;
               adj[i][j] = W'(w);
            end
   endtask

   task automatic run_graph(input int s, input int pulse_at);
      int cnt;
      model_run(s);
      @(negedge clk);
      src   = PW'(s);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt   = 0;
      while (!done && cnt < TIMEOUT) begin
         start = (cnt == pulse_at);
         src   = PW'($urandom_range(N - 1, 0));
         @(negedge clk);
         cnt++;
      end
      start = 1'b0;
      check("done_within_budget", done, 1);
      if (!done) begin
         exp_res_q.delete();
         exp_lat_q.delete();
         exp_mem_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_neg_cycle"}, neg_cycle, 0);
      check({tag, "_passes"}, passes_used, 0);
      check({tag, "_cycle_vertex"}, cycle_vertex, 0);
      check({tag, "_we"}, {we_a, we_b}, 0);
      check({tag, "_addr"}, {row_addr, col_addr, addr_a, addr_b}, 0);
   endtask

   task automatic abort_run(input int s, input int after);
      @(negedge clk);
      src   = PW'(s);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (after) @(negedge clk);
      check("abort_busy_before_reset", busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check_idle_outputs("mid_reset");
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      clear_graph();
      for (int v = 0; v < N; v++) vm[v] = '0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // line graph: dist {0,5,3,6}, pred {0,0,1,2}
      clear_graph();
      set_edge(0, 1, 5); set_edge(1, 2, -2); set_edge(2, 3, 3);
      run_graph(0, -1);

      // closing edge makes 1->2->3->1 sum -6
      set_edge(3, 1, -7);
      run_graph(0, -1);

      // single edge: early exit after second pass
      clear_graph();
      set_edge(0, 1, 4);
      run_graph(0, -1);

      // negative edge out of an unreachable vertex
      set_edge(5, 6, -100);
      run_graph(0, -1);

      // negative self loop reachable from source
      clear_graph();
      set_edge(0, 2, 1); set_edge(2, 2, -1);
      run_graph(0, -1);

      // non-zero source, positive weights
      rand_graph(35, 1, 20, 0);
      run_graph(N - 1, -1);

      // start pulsed while busy must be ignored
      rand_graph(30, -3, 15, 0);
      run_graph(2, 40);

      // reset mid-run, then rerun the same graph
      abort_run(1, 300);
      run_graph(1, -1);

      for (int t = 0; t < 6; t++) begin
         rand_graph(int'($urandom_range(50, 10)), -6, 25, 0);
         run_graph(int'($urandom_range(N - 1, 0)), -1);
      end

      // weights near the signed limits force saturation
      for (int t = 0; t < 4; t++) begin
         rand_graph(40, 0, 0, 1);
         run_graph(int'($urandom_range(N - 1, 0)), -1);
      end

      repeat (5) @(negedge clk);
      check("leftover_expectations", exp_res_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
